// File: rtl/outbuf_user_drain.sv
// Drains the output-buffer FIFO and streams each word to the user as MSB-first narrow beats.
// Optional second word register for gapless streaming: define OUTBUF_DRAIN_PREFETCH_EN.
module outbuf_user_drain #(
  parameter int PACKET_LENGTH          = 2,
  parameter int W                      = 4,
  parameter int PCK_TREE_XOR_UNITS_NUM = 6,
  parameter int OUTBUF_DATA_W          = PACKET_LENGTH * W * PCK_TREE_XOR_UNITS_NUM,
  parameter int USER_DATA_W            = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     outbuf_fifo_cntl_empty,
  input  logic                     outbuf_user_rd_ack,
  input  logic                     outbuf_dout_reg_val,
  input  logic [OUTBUF_DATA_W-1:0] outbuf_dout_reg,
  output logic                     user_outbuf_rd_req,
  output logic [USER_DATA_W-1:0]   user_dout,
  output logic                     user_dout_val,
  input  logic                     user_dout_rdy,
  output logic                     user_dout_last,
  output logic [15:0]              user_word_cnt,
  output logic                     drain_busy,
  output logic                     drain_err
);

  localparam int BEATS = OUTBUF_DATA_W / USER_DATA_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  if ((OUTBUF_DATA_W % USER_DATA_W) != 0) begin : g_width_check
    $error("USER_DATA_W must divide OUTBUF_DATA_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic [OUTBUF_DATA_W-1:0] shift_r, shift_s;
  logic [IDX_W-1:0]         idx_r, idx_s;
  logic [15:0]              word_cnt_r, word_cnt_s;
  logic                     err_r, err_s;
  logic                     rd_req_s;
  logic                     xfer_s;
  logic                     last_xfer_s;
  logic                     data_ok_s;

`ifdef OUTBUF_DRAIN_PREFETCH_EN
  logic [OUTBUF_DATA_W-1:0] pf_word_r, pf_word_s;
  logic                     pf_val_r, pf_val_s;
  logic                     pf_pend_r, pf_pend_s;
`endif

  // Next-state, datapath and read-request decode
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    idx_s       = idx_r;
    word_cnt_s  = word_cnt_r;
    err_s       = err_r;
    rd_req_s    = 1'b0;
    xfer_s      = (state_r == ST_SEND) & user_dout_rdy;
    last_xfer_s = xfer_s & (idx_r == LAST_IDX);
`ifdef OUTBUF_DRAIN_PREFETCH_EN
    pf_word_s   = pf_word_r;
    pf_val_s    = pf_val_r;
    pf_pend_s   = pf_pend_r;
    data_ok_s   = (state_r == ST_WAIT) | ((state_r == ST_SEND) & pf_pend_r);
`else
    data_ok_s   = (state_r == ST_WAIT);
`endif
    if (outbuf_dout_reg_val && !data_ok_s) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (!outbuf_fifo_cntl_empty) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        rd_req_s = 1'b1;
        if (outbuf_user_rd_ack) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (outbuf_dout_reg_val) begin
          shift_s = outbuf_dout_reg;
          idx_s   = '0;
          state_s = ST_SEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SEND: begin
`ifdef OUTBUF_DRAIN_PREFETCH_EN
        // Fetch the next word while the current one is still being beaten out
        rd_req_s = !pf_val_r & !outbuf_fifo_cntl_empty & !pf_pend_r;
        if (rd_req_s && outbuf_user_rd_ack) begin
          pf_pend_s = 1'b1;
        end else if (pf_pend_r && outbuf_dout_reg_val) begin
          pf_word_s = outbuf_dout_reg;
          pf_val_s  = 1'b1;
          pf_pend_s = 1'b0;
        end else begin
          pf_pend_s = pf_pend_r;
        end
`endif
        if (last_xfer_s) begin
          word_cnt_s = word_cnt_r + 16'd1;
`ifdef OUTBUF_DRAIN_PREFETCH_EN
          if (pf_val_r) begin
            shift_s  = pf_word_r;
            idx_s    = '0;
            pf_val_s = 1'b0;
            state_s  = ST_SEND;
          end else if (pf_pend_r && outbuf_dout_reg_val) begin
            shift_s   = outbuf_dout_reg;
            idx_s     = '0;
            pf_val_s  = 1'b0;
            pf_pend_s = 1'b0;
            state_s   = ST_SEND;
          end else if (pf_pend_r || (rd_req_s && outbuf_user_rd_ack)) begin
            // A read is in flight; collect it through the normal wait path
            pf_pend_s = 1'b0;
            state_s   = ST_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else if (xfer_s) begin
          shift_s = shift_r << USER_DATA_W;
          idx_s   = idx_r + IDX_W'(1);
          state_s = ST_SEND;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Main state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      idx_r      <= '0;
      word_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      idx_r      <= idx_s;
      word_cnt_r <= word_cnt_s;
      err_r      <= err_s;
    end
  end

`ifdef OUTBUF_DRAIN_PREFETCH_EN
  // Prefetch word register and outstanding-read flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_word_r <= '0;
      pf_val_r  <= 1'b0;
      pf_pend_r <= 1'b0;
    end else begin
      pf_word_r <= pf_word_s;
      pf_val_r  <= pf_val_s;
      pf_pend_r <= pf_pend_s;
    end
  end
`endif

  assign user_outbuf_rd_req = rd_req_s;
  assign user_dout          = shift_r[OUTBUF_DATA_W-1 -: USER_DATA_W];
  assign user_dout_val      = (state_r == ST_SEND);
  assign user_dout_last     = (state_r == ST_SEND) & (idx_r == LAST_IDX);
  assign user_word_cnt      = word_cnt_r;
  assign drain_busy         = (state_r != ST_IDLE);
  assign drain_err          = err_r;

endmodule
